svm_matmul_engine: RTL and testbench

SVM_MATMUL_ENGINE -- requirements
Module: svm_matmul_engine

---
 rtl/svm_pkg.sv | 27 ++
 rtl/svm_mac_lane.sv | 49 ++++
 rtl/svm_matmul_engine.sv | 183 ++++++++++++++++++
 tb/tb_svm_matmul_engine.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/svm_pkg.sv
// Shared types and width helpers for the SVM matrix-multiply engine.
// Holds the FSM state enum and the ACC_W / NGROUPS derivations.
package svm_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_FLUSH,
        S_EMIT
    } state_t;

    // Accumulator width: full square of an NBITS+1 difference plus
    // log2(F_WIDTH) bits of summation growth.
    function automatic int acc_w(input int nbits, input int f_width);
        return 2 * nbits + 2 + $clog2(f_width);
    endfunction

    function automatic int ngroups(input int sup, input int lanes);
        return (sup + lanes - 1) / lanes;
    endfunction

    // Counter width that never collapses to zero bits.
    function automatic int bits_for(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/svm_mac_lane.sv
// One MAC lane: accumulates x*s (mode 0) or (x-s)^2 (mode 1).
// Ports: clk, rst_n, clr, en, mode, x, s in; acc out.
module svm_mac_lane
    import svm_pkg::*;
#(
    parameter int NBITS = 16,
    parameter int ACC_W = 37
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clr,
    input  logic                    en,
    input  logic                    mode,
    input  logic signed [NBITS-1:0] x,
    input  logic signed [NBITS-1:0] s,
    output logic signed [ACC_W-1:0] acc
);

    localparam int PW = 2 * NBITS;
    localparam int SW = 2 * NBITS + 2;

    logic signed [NBITS:0]   diff;
    logic signed [PW-1:0]    prod;
    logic signed [SW-1:0]    sq;
    logic signed [ACC_W-1:0] term;

    always_comb begin
        // One extra bit so the difference of two extremes cannot wrap.
        diff = {x[NBITS-1], x} - {s[NBITS-1], s};
        prod = x * s;
        sq   = diff * diff;
        if (mode) begin
            term = {{(ACC_W - SW){sq[SW-1]}}, sq};
        end else begin
            term = {{(ACC_W - PW){prod[PW-1]}}, prod};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (clr) begin
            acc <= '0;
        end else if (en) begin
            acc <= acc + term;
        end
    end

endmodule

// File: rtl/svm_matmul_engine.sv
// SVM kernel engine: feature vector against a ROM of support vectors,
// LANES vectors per group, results streamed one index per beat.
// Ports: clk, rst_n; start/start_ready/mode/features job request;
// rom_en/rom_addr/rom_data support ROM; res_* result stream; busy.
module svm_matmul_engine
    import svm_pkg::*;
#(
    parameter int NBITS     = 16,
    parameter int F_WIDTH   = 8,
    parameter int SUP_WIDTH = 10,
    parameter int LANES     = 4,
    localparam int ACC_W    = acc_w(NBITS, F_WIDTH),
    localparam int NGROUPS  = ngroups(SUP_WIDTH, LANES),
    localparam int ADDR_W   = bits_for(NGROUPS * F_WIDTH),
    localparam int IDX_W    = bits_for(SUP_WIDTH)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    output logic                     start_ready,
    input  logic                     mode,
    input  logic [NBITS*F_WIDTH-1:0] features,
    output logic                     rom_en,
    output logic [ADDR_W-1:0]        rom_addr,
    input  logic [NBITS*LANES-1:0]   rom_data,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [ACC_W-1:0]         res_data,
    output logic [IDX_W-1:0]         res_idx,
    output logic                     res_last,
    output logic                     busy
);

    localparam int GW = bits_for(NGROUPS);
    localparam int LW = bits_for(LANES);
    localparam int FW = bits_for(F_WIDTH);
    // Index math runs one bit wider: the padded last group can
    // address past SUP_WIDTH-1.
    localparam int XW = IDX_W + 1;

    state_t state;
    state_t nstate;

    logic signed [NBITS-1:0] feat_q [F_WIDTH];
    logic                    mode_q;
    logic [GW-1:0]           group;
    logic [FW-1:0]           f;
    logic [FW-1:0]           rd_f;
    logic [LW-1:0]           lane;
    logic                    rd_valid;

    logic [XW-1:0]           base;
    logic [XW-1:0]           idx;
    logic [ADDR_W-1:0]       addr;
    logic                    accept;
    logic                    hs;
    logic                    fetch_end;
    logic                    lane_end;
    logic                    is_final;
    logic                    clr;
    logic signed [NBITS-1:0] x_cur;
    logic signed [ACC_W-1:0] acc [LANES];

    always_comb begin
        base      = XW'(group) * XW'(LANES);
        idx       = base + XW'(lane);
        addr      = ADDR_W'(group) * ADDR_W'(F_WIDTH) + ADDR_W'(f);
        fetch_end = (f == FW'(F_WIDTH - 1));
        lane_end  = (lane == LW'(LANES - 1));
        is_final  = (idx == XW'(SUP_WIDTH - 1));
        accept    = start && (state == S_IDLE);
        hs        = res_ready && (state == S_EMIT);
        // Clear on every entry into FETCH.
        clr       = accept || (hs && lane_end && !is_final);
        // Feature matching the ROM word arriving this cycle.
        x_cur     = feat_q[rd_f];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= nstate;
        end
    end

    always_comb begin
        nstate = state;
        unique case (state)
            S_IDLE: begin
                if (start) nstate = S_FETCH;
            end
            S_FETCH: begin
                if (fetch_end) nstate = S_FLUSH;
            end
            S_FLUSH: begin
                nstate = S_EMIT;
            end
            S_EMIT: begin
                if (res_ready) begin
                    if (is_final) begin
                        nstate = S_IDLE;
                    end else if (lane_end) begin
                        nstate = S_FETCH;
                    end
                end
            end
            default: nstate = S_IDLE;
        endcase
    end

    always_comb begin
        start_ready = (state == S_IDLE);
        busy        = (state != S_IDLE);
        rom_en      = (state == S_FETCH);
        rom_addr    = (state == S_FETCH) ? addr : '0;
        res_valid   = (state == S_EMIT);
        res_last    = (state == S_EMIT) && is_final;
        res_idx     = (state == S_EMIT) ? idx[IDX_W-1:0] : '0;
        res_data    = (state == S_EMIT) ? acc[lane] : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < F_WIDTH; i++) begin
                feat_q[i] <= '0;
            end
            mode_q   <= 1'b0;
            group    <= '0;
            f        <= '0;
            rd_f     <= '0;
            lane     <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= (state == S_FETCH);
            rd_f     <= f;
            if (accept) begin
                for (int i = 0; i < F_WIDTH; i++) begin
                    feat_q[i] <= features[i*NBITS +: NBITS];
                end
                mode_q <= mode;
                group  <= '0;
                f      <= '0;
                lane   <= '0;
            end
            if (state == S_FETCH) begin
                f <= fetch_end ? '0 : f + 1'b1;
            end
            if (hs) begin
                if (is_final) begin
                    group <= '0;
                    lane  <= '0;
                end else if (lane_end) begin
                    group <= group + 1'b1;
                    lane  <= '0;
                end else begin
                    lane <= lane + 1'b1;
                end
            end
        end
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic live;
        // Padding lanes of a partial last group never accumulate.
        assign live = (base + XW'(l)) < XW'(SUP_WIDTH);

        svm_mac_lane #(
            .NBITS(NBITS),
            .ACC_W(ACC_W)
        ) u_lane (
            .clk  (clk),
            .rst_n(rst_n),
            .clr  (clr),
            .en   (rd_valid && live),
            .mode (mode_q),
            .x    (x_cur),
            .s    (rom_data[l*NBITS +: NBITS]),
            .acc  (acc[l])
        );
    end

endmodule

// File: tb/tb_svm_matmul_engine.sv
// Self-checking bench for svm_matmul_engine at default parameters.
// Table-driven jobs, scoreboard of expected beats, corner sequences.
module tb_svm_matmul_engine;

    localparam int NB  = 16;
    localparam int F   = 8;
    localparam int S   = 10;
    localparam int L   = 4;
    localparam int AW  = 37;
    localparam int NG  = 3;
    localparam int ADW = 5;
    localparam int IW  = 4;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            start = 1'b0;
    logic            mode = 1'b0;
    logic            res_ready = 1'b1;
    logic [NB*F-1:0] features = '0;
    logic [NB*L-1:0] rom_data = '0;
    logic            start_ready;
    logic            rom_en;
    logic [ADW-1:0]  rom_addr;
    logic            res_valid;
    logic [AW-1:0]   res_data;
    logic [IW-1:0]   res_idx;
    logic            res_last;
    logic            busy;

    svm_matmul_engine dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .start_ready(start_ready),
        .mode       (mode),
        .features   (features),
        .rom_en     (rom_en),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data),
        .res_idx    (res_idx),
        .res_last   (res_last),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        longint data;
        int     idx;
        bit     last;
    } beat_t;

    typedef struct {
        bit     mode;
        int     fv;
        int     sv;
        bit     rnd;
        longint exp;
    } vec_t;

    beat_t   q[$];
    vec_t    tbl [6];
    shortint sup_mem [S][F];
    shortint feat [F];
    int      n_vec = 0;
    int      n_bad = 0;
    int      beats = 0;

    bit            prev_stall = 1'b0;
    logic [AW-1:0] prev_data = '0;
    logic [IW-1:0] prev_idx = '0;

    task automatic chk(input string nm, input longint act,
                       input longint exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", nm, act, exp);
        end
    endtask

    function automatic logic [NB*L-1:0] rom_word(input logic [ADW-1:0] a);
        logic [NB*L-1:0] w;
        int g;
        int fi;
        int id;
        g  = int'(a) / F;
        fi = int'(a) % F;
        w  = '0;
        for (int l = 0; l < L; l++) begin
            id = g * L + l;
            if (id < S) w[l*NB +: NB] = sup_mem[id][fi];
            else        w[l*NB +: NB] = NB'($urandom);
        end
        return w;
    endfunction

    // Support ROM: one cycle read latency, garbage on padding lanes.
    always @(posedge clk) begin
        if (rom_en) rom_data <= rom_word(rom_addr);
    end

    function automatic longint model(input int id, input bit m);
        longint sum;
        longint d;
        sum = 0;
        for (int j = 0; j < F; j++) begin
            if (m) begin
                d   = longint'(feat[j]) - longint'(sup_mem[id][j]);
                sum = sum + d * d;
            end else begin
                sum = sum + longint'(feat[j]) * longint'(sup_mem[id][j]);
            end
        end
        return sum;
    endfunction

    task automatic push_job(input bit m, input bit use_c,
                            input longint c);
        beat_t b;
        for (int i = 0; i < S; i++) begin
            b.data = use_c ? c : model(i, m);
            b.idx  = i;
            b.last = (i == S - 1);
            q.push_back(b);
        end
    endtask

    task automatic fill_uniform(input int fv, input int sv);
        for (int j = 0; j < F; j++) begin
            feat[j] = shortint'(fv);
            for (int i = 0; i < S; i++) sup_mem[i][j] = shortint'(sv);
        end
    endtask

    task automatic fill_random();
        for (int j = 0; j < F; j++) begin
            feat[j] = shortint'($urandom);
            for (int i = 0; i < S; i++) sup_mem[i][j] = shortint'($urandom);
        end
    endtask

    task automatic load_features();
        for (int j = 0; j < F; j++) features[j*NB +: NB] = feat[j];
    endtask

    // Scoreboard monitor: sampled on the falling edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall <= 1'b0;
        end else begin
            if (prev_stall) begin
                chk("stall_valid", longint'(res_valid), 1);
                chk("stall_data", longint'(res_data == prev_data), 1);
                chk("stall_idx", longint'(res_idx == prev_idx), 1);
            end
            if (res_valid && res_ready) begin
                beats++;
                if (q.size() == 0) begin
                    chk("unexpected_beat", longint'(res_idx), -1);
                end else begin
                    beat_t e;
                    e = q.pop_front();
                    chk("res_data", longint'($signed(res_data)), e.data);
                    chk("res_idx", longint'(res_idx), longint'(e.idx));
                    chk("res_last", longint'(res_last), longint'(e.last));
                end
            end
            prev_stall <= res_valid && !res_ready;
            prev_data  <= res_data;
            prev_idx   <= res_idx;
        end
    end

    task automatic run_job(input bit m, input bit rnd, input bit disturb,
                           output int first, output int done);
        int cnt;
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        load_features();
        mode  = m;
        start = 1'b1;
        chk("start_ready_idle", longint'(start_ready), 1);
        beats = 0;
        @(posedge clk);
        #1;
        start = 1'b0;
        cnt   = 0;
        first = 0;
        done  = 0;
        while (cnt < 3000 && done == 0) begin
            @(negedge clk);
            cnt++;
            if (res_valid && first == 0) first = cnt;
            if (start_ready) done = cnt;
            if (disturb && cnt == 4) begin
                chk("start_ready_busy", longint'(start_ready), 0);
                chk("busy_fetch", longint'(busy), 1);
            end
            @(posedge clk);
            #1;
            res_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (disturb && cnt == 3) begin
                start = 1'b1;
                mode  = ~m;
                for (int j = 0; j < F; j++) begin
                    features[j*NB +: NB] = 16'h7abc ^ 16'(j);
                end
            end
            if (disturb && cnt == 6) start = 1'b0;
        end
        if (done == 0) chk("job_timeout", 0, 1);
        chk("beat_count", longint'(beats), S);
        chk("queue_empty", longint'(q.size()), 0);
        res_ready = 1'b1;
    endtask

    initial begin
        int first;
        int done;
        int cnt;
        int stale;

        tbl[0] = '{mode: 1'b0, fv: 1, sv: 2, rnd: 1'b0, exp: 64'sd16};
        tbl[1] = '{mode: 1'b1, fv: -32768, sv: 32767, rnd: 1'b0,
                   exp: 64'sd34358689800};
        tbl[2] = '{mode: 1'b0, fv: -3, sv: 5, rnd: 1'b1, exp: -64'sd120};
        tbl[3] = '{mode: 1'b1, fv: 7, sv: -4, rnd: 1'b1, exp: 64'sd968};
        tbl[4] = '{mode: 1'b0, fv: 32767, sv: -32768, rnd: 1'b0,
                   exp: -64'sd8589672448};
        tbl[5] = '{mode: 1'b1, fv: -32768, sv: -32768, rnd: 1'b1,
                   exp: 64'sd0};

        #2;
        chk("rst_start_ready", longint'(start_ready), 1);
        chk("rst_busy", longint'(busy), 0);
        chk("rst_rom_en", longint'(rom_en), 0);
        chk("rst_res_valid", longint'(res_valid), 0);
        chk("rst_res_data", longint'(res_data), 0);
        @(negedge clk);
        #2;
        rst_n = 1'b1;

        for (int v = 0; v < 6; v++) begin
            fill_uniform(tbl[v].fv, tbl[v].sv);
            push_job(tbl[v].mode, 1'b1, tbl[v].exp);
            run_job(tbl[v].mode, tbl[v].rnd, 1'b0, first, done);
            chk("first_valid", longint'(first), F + 2);
            if (!tbl[v].rnd) begin
                chk("job_cycles", longint'(done), NG * (F + 1) + S + 1);
            end
        end

        for (int k = 0; k < 2; k++) begin
            fill_random();
            push_job(1'(k), 1'b0, 0);
            run_job(1'(k), 1'b1, 1'b0, first, done);
        end

        fill_random();
        push_job(1'b0, 1'b0, 0);
        run_job(1'b0, 1'b0, 1'b1, first, done);
        chk("dist_first_valid", longint'(first), F + 2);
        chk("dist_job_cycles", longint'(done), NG * (F + 1) + S + 1);

        // Abort in the middle of group 1's result stream.
        fill_uniform(1, 2);
        push_job(1'b0, 1'b1, 16);
        @(posedge clk);
        #1;
        load_features();
        mode  = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        cnt   = 0;
        while (cnt < 200 && !(res_valid && res_idx == 4'd4)) begin
            @(negedge clk);
            cnt++;
        end
        if (cnt >= 200) chk("emit_g1_timeout", 0, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_start_ready", longint'(start_ready), 1);
        chk("abort_busy", longint'(busy), 0);
        chk("abort_rom_en", longint'(rom_en), 0);
        chk("abort_rom_addr", longint'(rom_addr), 0);
        chk("abort_res_valid", longint'(res_valid), 0);
        chk("abort_res_last", longint'(res_last), 0);
        chk("abort_res_idx", longint'(res_idx), 0);
        chk("abort_res_data", longint'(res_data), 0);
        q.delete();
        repeat (2) @(negedge clk);
        #2;
        rst_n = 1'b1;
        stale = 0;
        repeat (40) begin
            @(negedge clk);
            if (res_valid || busy) stale++;
        end
        chk("no_stale_beat", longint'(stale), 0);

        fill_random();
        push_job(1'b1, 1'b0, 0);
        run_job(1'b1, 1'b0, 1'b0, first, done);
        chk("post_rst_first", longint'(first), F + 2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
